// File: rtl/core_dma_pkg.sv
// Shared types and constants for the CPU bus DMA arbiter.
// next_dma_state picks the next bus owner from the parity of the upcoming cycle.
package core_dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      OAM_GET,
      OAM_PUT,
      DMC_GET
   } dma_arb_state_type;

   localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
   localparam logic [15:0] OAM_PORT_ADDR = 16'h2004;

   // DMC wins get cycles; a fetched OAM byte always gets its put before anything else.
   function automatic dma_arb_state_type next_dma_state(
      input logic upcoming_get,
      input logic dmc_pend,
      input logic oam_pend,
      input logic have_byte
   );
      dma_arb_state_type nxt;
      if (upcoming_get) begin
         if (dmc_pend)      nxt = DMC_GET;
         else if (oam_pend) nxt = OAM_GET;
         else               nxt = IDLE;
      end else begin
         if (have_byte)                 nxt = OAM_PUT;
         else if (dmc_pend || oam_pend) nxt = ALIGN;
         else                           nxt = IDLE;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/core_dma_arbiter.sv
// Arbitrates the shared CPU bus between the CPU, OAM sprite DMA and DMC sample fetches.
// The CPU is halted through O_ready while any DMA owns the bus.
//
// state   | meaning
// IDLE    | CPU owns the bus, no DMA pending
// HALT    | CPU stalled; its current read repeats on the bus
// ALIGN   | dummy CPU-address read to reach the right get/put parity
// OAM_GET | read byte {page,offs}
// OAM_PUT | write latched byte to the OAM port
// DMC_GET | read one DMC sample byte
module core_dma_arbiter
   import core_dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG  = DMA_REG_ADDR,
   parameter logic [15:0] OAM_PORT = OAM_PORT_ADDR
) (
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic        I_phy2_tick,
   input  logic [15:0] I_cpu_addr,
   input  logic [7:0]  I_cpu_wr_data,
   input  logic        I_cpu_rdwr,
   input  logic [7:0]  I_rd_data,
   input  logic        I_dmc_req,
   input  logic [15:0] I_dmc_addr,
   output logic        O_dmc_ack,
   output logic [7:0]  O_dmc_data,
   output logic        O_ready,
   output logic        O_busy,
   output logic [15:0] O_addr,
   output logic [7:0]  O_wr_data,
   output logic        O_rdwr
);

   dma_arb_state_type state;
   logic       parity;
   logic       oam_pend;
   logic       dmc_pend;
   logic       have_byte;
   logic [7:0] page;
   logic [7:0] offs;
   logic [7:0] latch;

   logic       cpu_trig;
   logic       oam_pend_nxt;
   logic       dmc_pend_nxt;
   logic       have_byte_nxt;

   // Writes to the DMA register only count while the CPU is actually running.
   assign cpu_trig = (state == IDLE) && !I_cpu_rdwr && (I_cpu_addr == DMA_REG);

   // The scheduler looks at the flags as they will be after this tick.
   always_comb begin
      oam_pend_nxt  = oam_pend | cpu_trig;
      dmc_pend_nxt  = dmc_pend | I_dmc_req;
      have_byte_nxt = have_byte;
      case (state)
         OAM_GET: have_byte_nxt = 1'b1;
         OAM_PUT: begin
            have_byte_nxt = 1'b0;
            if (offs == 8'hFF) oam_pend_nxt = 1'b0;
         end
         DMC_GET: dmc_pend_nxt = I_dmc_req;
         default: ;
      endcase
   end

   always_comb begin
      O_addr    = I_cpu_addr;
      O_wr_data = I_cpu_wr_data;
      O_rdwr    = I_cpu_rdwr;
      case (state)
         ALIGN: O_rdwr = 1'b1;
         OAM_GET: begin
            O_addr = {page, offs};
            O_rdwr = 1'b1;
         end
         OAM_PUT: begin
            O_addr    = OAM_PORT;
            O_wr_data = latch;
            O_rdwr    = 1'b0;
         end
         DMC_GET: begin
            O_addr = I_dmc_addr;
            O_rdwr = 1'b1;
         end
         default: ;
      endcase
   end

   assign O_ready = (state == IDLE);
   assign O_busy  = oam_pend | dmc_pend;

   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         state      <= IDLE;
         parity     <= 1'b0;
         oam_pend   <= 1'b0;
         dmc_pend   <= 1'b0;
         have_byte  <= 1'b0;
         page       <= 8'h00;
         offs       <= 8'h00;
         latch      <= 8'h00;
         O_dmc_ack  <= 1'b0;
         O_dmc_data <= 8'h00;
      end else begin
         O_dmc_ack <= 1'b0;
         if (I_phy2_tick) begin
            parity    <= ~parity;
            oam_pend  <= oam_pend_nxt;
            dmc_pend  <= dmc_pend_nxt;
            have_byte <= have_byte_nxt;
            if (cpu_trig) begin
               page <= I_cpu_wr_data;
               offs <= 8'h00;
            end
            if (state == OAM_GET) latch <= I_rd_data;
            if (state == OAM_PUT) offs <= offs + 8'h01;
            if (state == DMC_GET) begin
               O_dmc_data <= I_rd_data;
               O_dmc_ack  <= 1'b1;
            end
            // parity=1 now means the coming cycle has parity 0, i.e. a get cycle
            if (state == IDLE)
               state <= (oam_pend_nxt || dmc_pend_nxt) ? HALT : IDLE;
            else
               state <= next_dma_state(parity, dmc_pend_nxt, oam_pend_nxt, have_byte_nxt);
         end
      end
   end

endmodule

// File: tb/tb_core_dma_arbiter.sv
// Directed bench for core_dma_arbiter: a vector table for short DMC sequences and
// hand-written OAM, mid-transfer reset and DMC merge/re-arm sequences.
module tb_core_dma_arbiter;

   logic        clk_sys = 1'b0;
   logic        rst_b;
   logic        tick;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wr;
   logic        cpu_rdwr;
   logic [7:0]  rd_data;
   logic        dmc_req;
   logic [15:0] dmc_addr;
   logic        ack;
   logic [7:0]  dd;
   logic        rdy;
   logic        busy;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wd;
   logic        bus_rw;

   int   checks = 0;
   int   errors = 0;
   logic p;

   core_dma_arbiter dut (
      .I_clock       (clk_sys),
      .I_reset       (rst_b),
      .I_phy2_tick   (tick),
      .I_cpu_addr    (cpu_addr),
      .I_cpu_wr_data (cpu_wr),
      .I_cpu_rdwr    (cpu_rdwr),
      .I_rd_data     (rd_data),
      .I_dmc_req     (dmc_req),
      .I_dmc_addr    (dmc_addr),
      .O_dmc_ack     (ack),
      .O_dmc_data    (dd),
      .O_ready       (rdy),
      .O_busy        (busy),
      .O_addr        (bus_addr),
      .O_wr_data     (bus_wd),
      .O_rdwr        (bus_rw)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  w;
      logic        rw;
      logic        req;
      logic [15:0] da;
      logic [7:0]  rd;
      logic        e_rdy;
      logic        e_busy;
      logic [15:0] e_addr;
      logic [7:0]  e_wd;
      logic        e_rw;
      logic        e_ack;
      logic [7:0]  e_dd;
   } vec_t;

   vec_t vt[10];

   task automatic step();
      @(negedge clk_sys);
      tick = 1'b1;
      @(negedge clk_sys);
      tick = 1'b0;
      p = ~p;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cpu_idle();
      cpu_addr = 16'h8010;
      cpu_wr   = 8'h00;
      cpu_rdwr = 1'b1;
      dmc_req  = 1'b0;
   endtask

   // Triggers OAM DMA from page pg with r_parity=trig_par at the trigger tick.
   // dmc_offs: pulse a DMC request during that put; stop_offs: return after that get.
   task automatic oam_run(input logic [7:0] pg, input logic trig_par, input int dmc_offs,
                          input int stop_offs, input int exp_len);
      int low;
      logic [7:0] d;
      logic [7:0] ib;
      low = 0;
      cpu_idle();
      if (p != trig_par) step();
      cpu_addr = 16'h4014;
      cpu_rdwr = 1'b0;
      cpu_wr   = pg;
      step(); if (!rdy) low++;
      cpu_idle();
      #1;
      chk("oam_halt", 64'({rdy, busy, bus_addr, bus_rw}), 64'({1'b0, 1'b1, 16'h8010, 1'b1}));
      if (trig_par) begin
         step(); if (!rdy) low++;
         chk("oam_align", 64'({rdy, busy, bus_addr, bus_rw}), 64'({1'b0, 1'b1, 16'h8010, 1'b1}));
      end
      for (int i = 0; i < 256; i++) begin
         ib = 8'(i);
         step(); if (!rdy) low++;
         chk($sformatf("oam_get_%0h_%0h", pg, ib), 64'({rdy, busy, bus_addr, bus_rw}),
             64'({1'b0, 1'b1, pg, ib, 1'b1}));
         if (i == stop_offs) return;
         d = pg ^ ib ^ 8'hA3;
         rd_data = d;
         step(); if (!rdy) low++;
         chk($sformatf("oam_put_%0h_%0h", pg, ib), 64'({rdy, busy, bus_addr, bus_wd, bus_rw}),
             64'({1'b0, 1'b1, 16'h2004, d, 1'b0}));
         if (i == dmc_offs) begin
            dmc_addr = 16'hC100;
            dmc_req  = 1'b1;
            step(); if (!rdy) low++;
            chk("dmc_mid_get", 64'({rdy, busy, bus_addr, bus_rw}), 64'({1'b0, 1'b1, 16'hC100, 1'b1}));
            dmc_req = 1'b0;
            rd_data = 8'h77;
            step(); if (!rdy) low++;
            chk("dmc_mid_align", 64'({rdy, busy, bus_addr, bus_rw, ack, dd}),
                64'({1'b0, 1'b1, 16'h8010, 1'b1, 1'b1, 8'h77}));
         end
      end
      step(); if (!rdy) low++;
      chk("oam_done", 64'({rdy, busy, bus_addr, bus_rw}), 64'({1'b1, 1'b0, 16'h8010, 1'b1}));
      chk("oam_len", 64'(low), 64'(exp_len));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int acks;
      logic [7:0] wd;
      logic [7:0] ewd;

      // DMC alone: HALT on put parity (no ALIGN), then HALT on get parity with ALIGN;
      // a $4014 write during ALIGN must be ignored.
      vt[0] = '{16'h8000, 8'h00, 1'b1, 1'b1, 16'hC000, 8'h00, 1'b0, 1'b1, 16'h8000, 8'h00, 1'b1, 1'b0, 8'h00};
      vt[1] = '{16'h8000, 8'h00, 1'b1, 1'b0, 16'hC000, 8'h00, 1'b0, 1'b1, 16'hC000, 8'h00, 1'b1, 1'b0, 8'h00};
      vt[2] = '{16'h8000, 8'h00, 1'b1, 1'b0, 16'hC000, 8'h5A, 1'b1, 1'b0, 16'h8000, 8'h00, 1'b1, 1'b1, 8'h5A};
      vt[3] = '{16'h4000, 8'h33, 1'b0, 1'b0, 16'hC000, 8'h00, 1'b1, 1'b0, 16'h4000, 8'h33, 1'b0, 1'b0, 8'h5A};
      vt[4] = '{16'h8001, 8'h00, 1'b1, 1'b0, 16'hC000, 8'h00, 1'b1, 1'b0, 16'h8001, 8'h00, 1'b1, 1'b0, 8'h5A};
      vt[5] = '{16'h8002, 8'h00, 1'b1, 1'b1, 16'hC001, 8'h00, 1'b0, 1'b1, 16'h8002, 8'h00, 1'b1, 1'b0, 8'h5A};
      vt[6] = '{16'h4014, 8'h07, 1'b0, 1'b0, 16'hC001, 8'h00, 1'b0, 1'b1, 16'h4014, 8'h00, 1'b1, 1'b0, 8'h5A};
      vt[7] = '{16'h8002, 8'h00, 1'b1, 1'b0, 16'hC001, 8'h00, 1'b0, 1'b1, 16'hC001, 8'h00, 1'b1, 1'b0, 8'h5A};
      vt[8] = '{16'h8002, 8'h00, 1'b1, 1'b0, 16'hC001, 8'hA5, 1'b1, 1'b0, 16'h8002, 8'h00, 1'b1, 1'b1, 8'hA5};
      vt[9] = '{16'h8002, 8'h00, 1'b1, 1'b0, 16'hC001, 8'h00, 1'b1, 1'b0, 16'h8002, 8'h00, 1'b1, 1'b0, 8'hA5};

      rst_b    = 1'b0;
      tick     = 1'b0;
      cpu_addr = 16'h1234;
      cpu_wr   = 8'h9C;
      cpu_rdwr = 1'b0;
      dmc_req  = 1'b0;
      dmc_addr = 16'h0000;
      rd_data  = 8'h00;
      p        = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("rst_ctrl", 64'({rdy, busy, ack, dd}), 64'({1'b1, 1'b0, 1'b0, 8'h00}));
      chk("rst_bus", 64'({bus_addr, bus_wd, bus_rw}), 64'({16'h1234, 8'h9C, 1'b0}));
      rst_b = 1'b1;

      for (int i = 0; i < 10; i++) begin
         cpu_addr = vt[i].a;
         cpu_wr   = vt[i].w;
         cpu_rdwr = vt[i].rw;
         dmc_req  = vt[i].req;
         dmc_addr = vt[i].da;
         rd_data  = vt[i].rd;
         step();
         wd  = bus_rw ? 8'h00 : bus_wd;
         ewd = vt[i].e_rw ? 8'h00 : vt[i].e_wd;
         chk($sformatf("vec%0d", i), 64'({rdy, busy, bus_addr, wd, bus_rw, ack, dd}),
             64'({vt[i].e_rdy, vt[i].e_busy, vt[i].e_addr, ewd, vt[i].e_rw, vt[i].e_ack, vt[i].e_dd}));
      end

      oam_run(8'h02, 1'b1, -1, -1, 514);
      oam_run(8'h04, 1'b1, 16, -1, 516);

      oam_run(8'h05, 1'b0, -1, 8'h80, 0);
      #2 rst_b = 1'b0;
      #1;
      chk("mid_rst", 64'({rdy, busy, ack, dd, bus_addr, bus_rw}),
          64'({1'b1, 1'b0, 1'b0, 8'h00, 16'h8010, 1'b1}));
      @(negedge clk_sys);
      rst_b = 1'b1;
      p = 1'b0;
      oam_run(8'h03, 1'b0, -1, -1, 513);

      // Request held through the first ack: merge plus one re-arm.
      cpu_idle();
      dmc_addr = 16'hC200;
      rd_data  = 8'h11;
      dmc_req  = 1'b1;
      acks = 0;
      for (int k = 0; k < 16; k++) begin
         step();
         if (ack) begin
            acks++;
            chk("held_data", 64'(dd), 64'(8'h11));
            if (acks == 1) begin
               dmc_req = 1'b0;
               @(negedge clk_sys);
               chk("ack_pulse", 64'(ack), 64'(1'b0));
            end
         end
      end
      chk("held_fetches", 64'(acks), 64'(2));
      chk("held_idle", 64'({rdy, busy}), 64'({1'b1, 1'b0}));

      // Second pulse while still pending merges into the same fetch.
      if (p != 1'b1) step();
      dmc_addr = 16'hC300;
      rd_data  = 8'h22;
      acks = 0;
      dmc_req = 1'b1; step(); if (ack) acks++;
      dmc_req = 1'b0; step(); if (ack) acks++;
      dmc_req = 1'b1; step(); if (ack) acks++;
      dmc_req = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (ack) acks++;
      end
      chk("merge_fetches", 64'(acks), 64'(1));
      chk("merge_data", 64'({rdy, busy, dd}), 64'({1'b1, 1'b0, 8'h22}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
